menu_controller: RTL



---
 rtl/menu_controller.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/menu_controller.sv
// Pong game-flow sequencer: button conditioning, MENU/START/PLAY/OVER flow, menu cursor.
// Optional PAUSE state in PLAY is built when MENU_PAUSE_EN is defined.
module menu_controller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int unsigned NUM_ITEMS       = 4,
  parameter logic [7:0]  GAMEOVER_FRAMES = 8'd180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic       frame_tick,
  input  logic       winner,
  output logic       menu,
  output logic [1:0] cursor,
  output logic [1:0] mode,
  output logic       game_reset,
  output logic       game_run,
  output logic       show_winner
);

  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned CNT_W   = 16;
  localparam logic [1:0]  LAST    = 2'(NUM_ITEMS - 1);

`ifdef MENU_PAUSE_EN
  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_START = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3,
    ST_PAUSE = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_START = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3
  } state_e;
`endif

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] ev;
  logic               up_ev, down_ev, sel_ev;

  assign btn_raw = {btn_select, btn_down, btn_up};
  assign up_ev   = ev[0];
  assign down_ev = ev[1];
  assign sel_ev  = ev[2];

  // Per button: 2-flop sync, stability counter, registered press-edge pulse.
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    logic             s1_q, s2_q, db_q, db_d, dbp_q, ev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (s2_q == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        db_q  <= 1'b0;
        dbp_q <= 1'b0;
        ev_q  <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= btn_raw[b];
        s2_q  <= s1_q;
        db_q  <= db_d;
        dbp_q <= db_q;
        ev_q  <= db_q & ~dbp_q;
        cnt_q <= cnt_d;
      end
    end

    assign ev[b] = ev_q;
  end

  state_e     state_q, state_d;
  logic [1:0] cursor_q, cursor_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] over_cnt_q, over_cnt_d;
  logic       menu_q, game_reset_q, game_run_q, show_winner_q;

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    mode_d     = mode_q;
    over_cnt_d = over_cnt_q;
    case (state_q)
      ST_MENU: begin
        // Select has priority over a coincident move so mode sees the pre-move cursor.
        if (sel_ev) begin
          state_d = ST_START;
          mode_d  = cursor_q;
        end else if (up_ev && !down_ev) begin
          cursor_d = (cursor_q == 2'd0) ? LAST : cursor_q - 2'd1;
        end else if (down_ev && !up_ev) begin
          cursor_d = (cursor_q == LAST) ? 2'd0 : cursor_q + 2'd1;
        end
      end
      ST_START: state_d = ST_PLAY;
      ST_PLAY: begin
        if (winner) begin
          state_d    = ST_OVER;
          over_cnt_d = '0;
        end
`ifdef MENU_PAUSE_EN
        else if (sel_ev) begin
          state_d = ST_PAUSE;
        end
`endif
      end
      ST_OVER: begin
        if (sel_ev) begin
          state_d = ST_MENU;
        end else if (frame_tick) begin
          over_cnt_d = over_cnt_q + 8'd1;
          if (over_cnt_q == GAMEOVER_FRAMES - 8'd1) state_d = ST_MENU;
        end
      end
`ifdef MENU_PAUSE_EN
      ST_PAUSE: if (sel_ev) state_d = ST_PLAY;
`endif
      default: state_d = ST_MENU;
    endcase
  end

  // Moore outputs registered from next state so they align with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_MENU;
      cursor_q      <= 2'd0;
      mode_q        <= 2'd0;
      over_cnt_q    <= 8'd0;
      menu_q        <= 1'b1;
      game_reset_q  <= 1'b0;
      game_run_q    <= 1'b0;
      show_winner_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cursor_q      <= cursor_d;
      mode_q        <= mode_d;
      over_cnt_q    <= over_cnt_d;
      menu_q        <= (state_d == ST_MENU);
      game_reset_q  <= (state_d == ST_START);
      game_run_q    <= (state_d == ST_PLAY);
      show_winner_q <= (state_d == ST_OVER);
    end
  end

  assign menu        = menu_q;
  assign cursor      = cursor_q;
  assign mode        = mode_q;
  assign game_reset  = game_reset_q;
  assign game_run    = game_run_q;
  assign show_winner = show_winner_q;

endmodule
